// File: rtl/lsu_split_ctrl_pkg.sv
// Shared LSU types: access size, sequencer states and the ALU operand-B selects
// that the sequencer overrides while it fetches the second word of a split access.
package lsu_split_ctrl_pkg;

    typedef enum logic [1:0] {
        LSU_WORD = 2'b00,
        LSU_HALF = 2'b01,
        LSU_BYTE = 2'b10
    } lsu_type_e;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_GNT_MIS,
        WAIT_RVALID_MIS,
        WAIT_GNT,
        WAIT_RVALID
    } ls_fsm_e;

    typedef enum logic {
        OP_B_REG_OR_FWD,
        OP_B_IMM
    } op_b_sel_e;

    typedef enum logic [2:0] {
        IMM_B_I,
        IMM_B_S,
        IMM_B_B,
        IMM_B_U,
        IMM_B_J,
        IMM_B_INCR_PC,
        IMM_B_INCR_ADDR
    } imm_b_sel_e;

endpackage

// File: rtl/lsu_split_ctrl_if.sv
// EX-stage request, ALU address feedback and data-memory bus signals of the LSU sequencer.
// master = the sequencer itself, slave = the EX stage / memory side.
interface lsu_split_ctrl_if;
    import lsu_split_ctrl_pkg::*;

    logic        lsu_req_i;
    logic        lsu_we_i;
    lsu_type_e   lsu_type_i;
    logic [31:0] adder_result_i;
    logic        data_gnt_i;
    logic        data_rvalid_i;
    logic        data_err_i;

    logic        data_req_o;
    logic [31:0] data_addr_o;
    logic [3:0]  data_be_o;
    logic        data_we_o;
    logic        lsu_addr_incr_req_o;
    logic        busy_o;
    logic        lsu_done_o;
    logic        err_o;

    modport master (
        input  lsu_req_i, lsu_we_i, lsu_type_i, adder_result_i,
               data_gnt_i, data_rvalid_i, data_err_i,
        output data_req_o, data_addr_o, data_be_o, data_we_o,
               lsu_addr_incr_req_o, busy_o, lsu_done_o, err_o
    );

    modport slave (
        output lsu_req_i, lsu_we_i, lsu_type_i, adder_result_i,
               data_gnt_i, data_rvalid_i, data_err_i,
        input  data_req_o, data_addr_o, data_be_o, data_we_o,
               lsu_addr_incr_req_o, busy_o, lsu_done_o, err_o
    );

endinterface

// File: rtl/lsu_split_ctrl_be_gen.sv
// Byte-enable generator: maps access size and byte offset to the enables of the
// first or second word of an access, and flags accesses that straddle a word.
module lsu_split_ctrl_be_gen
    import lsu_split_ctrl_pkg::*;
(
    input  lsu_type_e  lsu_type,
    input  logic [1:0] offset,
    input  logic       phase2,
    output logic [3:0] be,
    output logic       misaligned
);

    always_comb begin
        be         = 4'b0000;
        misaligned = 1'b0;
        case (lsu_type)
            LSU_WORD: begin
                misaligned = (offset != 2'b00);
                if (!phase2) begin
                    be = 4'b1111 << offset;
                end else begin
                    case (offset)
                        2'd1:    be = 4'b0001;
                        2'd2:    be = 4'b0011;
                        2'd3:    be = 4'b0111;
                        default: be = 4'b0000;
                    endcase
                end
            end
            LSU_HALF: begin
                misaligned = (offset == 2'd3);
                if (!phase2) begin
                    case (offset)
                        2'd0:    be = 4'b0011;
                        2'd1:    be = 4'b0110;
                        2'd2:    be = 4'b1100;
                        default: be = 4'b1000;
                    endcase
                end else begin
                    be = (offset == 2'd3) ? 4'b0001 : 4'b0000;
                end
            end
            LSU_BYTE: begin
                be = phase2 ? 4'b0000 : (4'b0001 << offset);
            end
            default: begin
                be         = 4'b0000;
                misaligned = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/lsu_split_ctrl.sv
// Load/store sequencer: issues one or two word-aligned bus transactions per EX access,
// steering the ALU to addr+4 for the second word and stalling EX until the response.
module lsu_split_ctrl
    import lsu_split_ctrl_pkg::*;
#(
    parameter bit MisalignedEn = 1'b1
) (
    input logic              clk_i,
    input logic              rst_i,
    lsu_split_ctrl_if.master bus
);

    ls_fsm_e    state_q;
    logic       split_q;
    logic [1:0] offset_q;
    lsu_type_e  type_q;
    logic       we_q;

    logic       req_live;
    logic       in_idle;
    logic       phase2;
    logic       misaligned;
    logic       mis_fault;
    lsu_type_e  be_type;
    logic [1:0] be_offset;
    logic [3:0] be;
    logic       req;
    logic       done;
    logic       err;

    // A request seen while reset is held is not accepted, so every output stays low.
    assign req_live  = bus.lsu_req_i & ~rst_i;
    assign in_idle   = (state_q == IDLE);
    assign be_type   = in_idle ? bus.lsu_type_i : type_q;
    assign be_offset = in_idle ? bus.adder_result_i[1:0] : offset_q;
    assign phase2    = (state_q == WAIT_RVALID_MIS) | ((state_q == WAIT_GNT) & split_q);
    assign mis_fault = in_idle & req_live & misaligned & ~MisalignedEn;

    lsu_split_ctrl_be_gen u_be_gen (
        .lsu_type   (be_type),
        .offset     (be_offset),
        .phase2     (phase2),
        .be         (be),
        .misaligned (misaligned)
    );

    // Kept free of the address input so the ALU feedback path through adder_result_i has no loop.
    assign bus.lsu_addr_incr_req_o =
        ((state_q == WAIT_RVALID_MIS) & bus.data_rvalid_i & ~bus.data_err_i) |
        ((state_q == WAIT_GNT) & split_q);

    always_comb begin
        req  = 1'b0;
        done = 1'b0;
        err  = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_live) begin
                    if (mis_fault) begin
                        done = 1'b1;
                        err  = 1'b1;
                    end else begin
                        req = 1'b1;
                    end
                end
            end
            WAIT_GNT_MIS, WAIT_GNT: begin
                req = 1'b1;
            end
            WAIT_RVALID_MIS: begin
                if (bus.data_rvalid_i) begin
                    if (bus.data_err_i) begin
                        done = 1'b1;
                        err  = 1'b1;
                    end else begin
                        req = 1'b1;
                    end
                end
            end
            WAIT_RVALID: begin
                if (bus.data_rvalid_i) begin
                    done = 1'b1;
                    err  = bus.data_err_i;
                end
            end
            default: begin
                req  = 1'b0;
                done = 1'b0;
                err  = 1'b0;
            end
        endcase
    end

    assign bus.data_req_o  = req;
    assign bus.data_addr_o = req ? {bus.adder_result_i[31:2], 2'b00} : 32'd0;
    assign bus.data_be_o   = req ? be : 4'b0000;
    assign bus.data_we_o   = req & (in_idle ? bus.lsu_we_i : we_q);
    assign bus.lsu_done_o  = done;
    assign bus.err_o       = err;
    assign bus.busy_o      = ~in_idle | (req_live & ~done);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            split_q  <= 1'b0;
            offset_q <= 2'b00;
            type_q   <= LSU_WORD;
            we_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_live) begin
                        split_q  <= misaligned;
                        offset_q <= bus.adder_result_i[1:0];
                        type_q   <= bus.lsu_type_i;
                        we_q     <= bus.lsu_we_i;
                        if (!mis_fault) begin
                            if (misaligned) begin
                                state_q <= bus.data_gnt_i ? WAIT_RVALID_MIS : WAIT_GNT_MIS;
                            end else begin
                                state_q <= bus.data_gnt_i ? WAIT_RVALID : WAIT_GNT;
                            end
                        end
                    end
                end
                WAIT_GNT_MIS: begin
                    if (bus.data_gnt_i) state_q <= WAIT_RVALID_MIS;
                end
                WAIT_RVALID_MIS: begin
                    if (bus.data_rvalid_i) begin
                        if (bus.data_err_i) begin
                            state_q <= IDLE;
                        end else begin
                            state_q <= bus.data_gnt_i ? WAIT_RVALID : WAIT_GNT;
                        end
                    end
                end
                WAIT_GNT: begin
                    if (bus.data_gnt_i) state_q <= WAIT_RVALID;
                end
                WAIT_RVALID: begin
                    if (bus.data_rvalid_i) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_split_ctrl.sv
// Randomised bench for lsu_split_ctrl: a byte-range model predicts every bus beat,
// while the bench acts as ALU (addr / addr+4 feedback) and as the memory bus.
module tb_lsu_split_ctrl;
    import lsu_split_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    lsu_split_ctrl_if ifa ();
    lsu_split_ctrl_if ifb ();

    logic [31:0] addr_a;
    logic [31:0] addr_b;

    assign ifa.adder_result_i = ifa.lsu_addr_incr_req_o ? addr_a + 32'd4 : addr_a;
    assign ifb.adder_result_i = ifb.lsu_addr_incr_req_o ? addr_b + 32'd4 : addr_b;

    lsu_split_ctrl #(.MisalignedEn(1'b1)) u_dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (ifa.master)
    );

    lsu_split_ctrl #(.MisalignedEn(1'b0)) u_dut_nomis (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (ifb.master)
    );

    int n_vec = 0;
    int n_err = 0;
    int acc_id = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL acc%0d %s: got %h expected %h", acc_id, tag, got, exp);
        end
    endtask

    task automatic check_outs(input bit sel, input string tag, input logic req,
                              input logic [31:0] addr, input logic [3:0] be, input logic we,
                              input logic incr, input logic busy, input logic done,
                              input logic err);
        check({tag, ".req"},  sel ? ifb.data_req_o : ifa.data_req_o, 32'(req));
        check({tag, ".addr"}, sel ? ifb.data_addr_o : ifa.data_addr_o, addr);
        check({tag, ".be"},   32'(sel ? ifb.data_be_o : ifa.data_be_o), 32'(be));
        check({tag, ".we"},   sel ? ifb.data_we_o : ifa.data_we_o, 32'(we));
        check({tag, ".incr"}, sel ? ifb.lsu_addr_incr_req_o : ifa.lsu_addr_incr_req_o, 32'(incr));
        check({tag, ".busy"}, sel ? ifb.busy_o : ifa.busy_o, 32'(busy));
        check({tag, ".done"}, sel ? ifb.lsu_done_o : ifa.lsu_done_o, 32'(done));
        check({tag, ".err"},  sel ? ifb.err_o : ifa.err_o, 32'(err));
    endtask

    // The access covers bytes [a, a+size-1]; each touched word becomes one bus beat.
    function automatic void plan(input logic [31:0] a, input lsu_type_e t, output int nph,
                                 output logic [31:0] wa0, output logic [31:0] wa1,
                                 output logic [3:0] be0, output logic [3:0] be1);
        int unsigned size;
        logic [31:0] lo, hi;
        size = (t == LSU_WORD) ? 4 : (t == LSU_HALF) ? 2 : 1;
        lo   = a;
        hi   = a + size - 1;
        wa0  = a & 32'hFFFF_FFFC;
        wa1  = wa0 + 32'd4;
        be0  = 4'b0000;
        be1  = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            if (wa0 + 32'(i) >= lo && wa0 + 32'(i) <= hi) be0[i] = 1'b1;
            if (wa1 + 32'(i) >= lo && wa1 + 32'(i) <= hi) be1[i] = 1'b1;
        end
        nph = (be1 != 4'b0000) ? 2 : 1;
    endfunction

    // Called and returning at posedge+1; gd/rd are grant / response latencies per phase.
    task automatic run_access(input logic [31:0] a, input lsu_type_e t, input logic we,
                              input int gd0, input int gd1, input int rd0, input int rd1,
                              input int err_ph, input int gap);
        int nph, ph, cnt, budget;
        logic [31:0] wa0, wa1;
        logic [3:0] be0, be1;
        bit wait_rsp, fin, rv, er, gnt;
        acc_id++;
        plan(a, t, nph, wa0, wa1, be0, be1);
        ifa.lsu_req_i  = 1'b1;
        ifa.lsu_type_i = t;
        ifa.lsu_we_i   = we;
        addr_a         = a;
        ph = 0; cnt = 0; budget = 0; wait_rsp = 0; fin = 0;
        while (!fin) begin
            rv  = wait_rsp && (cnt == ((ph == 0) ? rd0 : rd1));
            er  = rv && (ph == err_ph);
            fin = rv && (er || ph == nph - 1);
            if (rv && !fin) begin
                ph = 1; wait_rsp = 0; cnt = 0;
            end
            gnt = !wait_rsp && !fin && (cnt == ((ph == 0) ? gd0 : gd1));
            ifa.data_gnt_i    = gnt;
            ifa.data_rvalid_i = rv;
            ifa.data_err_i    = er;
            @(negedge clk);
            if (fin)
                check_outs(0, "done", 0, 32'd0, 4'b0, 0, 0, 1, 1, er);
            else if (!wait_rsp)
                check_outs(0, (ph == 0) ? "req1" : "req2", 1, (ph == 0) ? wa0 : wa1,
                           (ph == 0) ? be0 : be1, we, (ph == 1), 1, 0, 0);
            else
                check_outs(0, "wait", 0, 32'd0, 4'b0, 0, 0, 1, 0, 0);
            @(posedge clk); #1;
            if (!fin) begin
                if (!wait_rsp && gnt) begin
                    wait_rsp = 1; cnt = 0;
                end else begin
                    cnt++;
                end
            end
            budget++;
            if (budget > 64) begin
                check("timeout", 32'd1, 32'd0);
                fin = 1;
            end
        end
        ifa.lsu_req_i     = 1'b0;
        ifa.data_gnt_i    = 1'b0;
        ifa.data_rvalid_i = 1'b0;
        ifa.data_err_i    = 1'b0;
        addr_a            = $urandom;
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            check_outs(0, "idle", 0, 32'd0, 4'b0, 0, 0, 0, 0, 0);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        rst = 1'b1;
        ifa.lsu_req_i = 0; ifa.lsu_we_i = 0; ifa.lsu_type_i = LSU_WORD;
        ifa.data_gnt_i = 0; ifa.data_rvalid_i = 0; ifa.data_err_i = 0;
        ifb.lsu_req_i = 0; ifb.lsu_we_i = 0; ifb.lsu_type_i = LSU_WORD;
        ifb.data_gnt_i = 0; ifb.data_rvalid_i = 0; ifb.data_err_i = 0;
        addr_a = 32'h0000_1002; addr_b = 32'h0000_1003;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_outs(0, "reset", 0, 32'd0, 4'b0, 0, 0, 0, 0, 0);
        check_outs(1, "reset_b", 0, 32'd0, 4'b0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        run_access(32'h0000_1000, LSU_WORD, 0, 0, 0, 2, 0, -1, 1);
        run_access(32'h0000_1002, LSU_WORD, 0, 0, 0, 1, 1, -1, 1);
        run_access(32'h0000_2003, LSU_HALF, 1, 3, 3, 1, 1, -1, 0);
        run_access(32'h0000_0010, LSU_WORD, 0, 0, 0, 1, 1, 0, 1);

        // Reset while the first word of a split load is outstanding.
        acc_id++;
        ifa.lsu_req_i = 1; ifa.lsu_type_i = LSU_WORD; ifa.lsu_we_i = 0;
        addr_a = 32'h0000_1002; ifa.data_gnt_i = 1;
        @(negedge clk);
        check_outs(0, "rst_req1", 1, 32'h0000_1000, 4'b1100, 0, 0, 1, 0, 0);
        @(posedge clk); #1;
        ifa.data_gnt_i = 0; rst = 1'b1;
        @(negedge clk);
        check_outs(0, "in_rst", 0, 32'd0, 4'b0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        rst = 1'b0; ifa.lsu_req_i = 0; ifa.data_rvalid_i = 1;
        @(negedge clk);
        check_outs(0, "stale_rsp", 0, 32'd0, 4'b0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        ifa.data_rvalid_i = 0;
        run_access(32'h0000_0003, LSU_BYTE, 0, 0, 0, 1, 0, -1, 1);

        // Instance without split support: misaligned word faults locally, aligned one runs.
        acc_id++;
        ifb.lsu_req_i = 1; ifb.lsu_type_i = LSU_WORD; addr_b = 32'h0000_1001;
        @(negedge clk);
        check_outs(1, "nomis_fault", 0, 32'd0, 4'b0, 0, 0, 0, 1, 1);
        @(posedge clk); #1;
        addr_b = 32'h0000_1000; ifb.data_gnt_i = 1;
        @(negedge clk);
        check_outs(1, "nomis_req", 1, 32'h0000_1000, 4'b1111, 0, 0, 1, 0, 0);
        @(posedge clk); #1;
        ifb.data_gnt_i = 0;
        @(negedge clk);
        check_outs(1, "nomis_wait", 0, 32'd0, 4'b0, 0, 0, 1, 0, 0);
        @(posedge clk); #1;
        ifb.data_rvalid_i = 1;
        @(negedge clk);
        check_outs(1, "nomis_done", 0, 32'd0, 4'b0, 0, 0, 1, 1, 0);
        @(posedge clk); #1;
        ifb.data_rvalid_i = 0; ifb.lsu_req_i = 0;
        @(negedge clk);
        check_outs(1, "nomis_idle", 0, 32'd0, 4'b0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;

        for (int k = 0; k < 300; k++) begin
            int e;
            lsu_type_e t;
            t = lsu_type_e'(2'($urandom_range(0, 2)));
            e = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 1)) : -1;
            run_access($urandom & 32'h0FFF_FFFF, t, 1'($urandom_range(0, 1)),
                       int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                       int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                       e, int'($urandom_range(0, 2)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
